// File: rtl/syn_s_info_rx_pkg.sv
// Shared state encodings and framing constants for the tx_info UTC-seconds receiver.
// The optional glitch filter (SYN_S_INFO_FILT_EN) uses the majority helper below.
package syn_s_info_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4,
        S_BREAK = 3'd5
    } state_e;

    localparam int TPER_MIN       = 4;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/syn_s_info_rx_if.sv
// Serial-line input, bit-period configuration and decoded UTC-seconds outputs of the receiver.
interface syn_s_info_rx_if
    import syn_s_info_rx_pkg::*;
#(
    parameter int CNT_W = 20
);
    logic              rx_info;
    logic [CNT_W-1:0]  tbit_period;
    logic [WORD_W-1:0] utc_sec;
    logic              utc_valid;
    logic              err_frame;
    logic              err_timeout;
    logic              busy;

    modport master (
        output rx_info, tbit_period,
        input  utc_sec, utc_valid, err_frame, err_timeout, busy
    );

    modport slave (
        input  rx_info, tbit_period,
        output utc_sec, utc_valid, err_frame, err_timeout, busy
    );
endinterface

// File: rtl/syn_s_info_rx_byte.sv
// Start/data/stop bit timing for one {0, d7..d0, 1} character; samples mid-bit from the start edge.
module syn_s_info_rx_byte
    import syn_s_info_rx_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             start,
    input  logic             line,
    input  logic [CNT_W-1:0] tbit_period,
    output logic             byte_done,
    output logic             stop_err,
    output logic             false_start,
    output logic [7:0]       byte_data,
    output logic [CNT_W-1:0] tper
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, tper_q, tper_d;
    logic [CNT_W-1:0] half_m1, tper_m1;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;

    assign half_m1   = (tper_q >> 1) - CNT_W'(1);
    assign tper_m1   = tper_q - CNT_W'(1);
    assign byte_data = sh_q;
    assign tper      = tper_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tper_q  <= CNT_W'(TPER_MIN);
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tper_q  <= tper_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        tper_d      = tper_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        byte_done   = 1'b0;
        stop_err    = 1'b0;
        false_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_START;
                    tper_d  = (tbit_period < CNT_W'(TPER_MIN)) ? CNT_W'(TPER_MIN) : tbit_period;
                end
            end
            S_START: begin
                if (cnt_q == half_m1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (line) begin
                        false_start = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == tper_m1) begin
                    cnt_d = '0;
                    sh_d  = {sh_q[6:0], line};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == tper_m1) begin
                    byte_done = line;
                    stop_err  = ~line;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: rtl/syn_s_info_rx.sv
// Slave receiver for the tx_info link: assembles four bytes (MSB byte first) into utc_sec.
// Define SYN_S_INFO_FILT_EN to insert a 3-sample majority glitch filter after the synchroniser.
module syn_s_info_rx
    import syn_s_info_rx_pkg::*;
#(
    parameter int TIMEOUT_BITS = 32,
    parameter int CNT_W        = 20
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    syn_s_info_rx_if.slave bus
);
    localparam int GAP_W = CNT_W + 6;

    logic [1:0]        sync_q, sync_d;
    logic              line, line_prev_q, line_prev_d, fall;
    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       word_q, word_d;
    logic [GAP_W-1:0]  gap_q, gap_d, gap_inc, timeout_lim, brk_lim;
    logic [WORD_W-1:0] utc_sec_q, utc_sec_d;
    logic              utc_valid_q, utc_valid_d;
    logic              err_frame_q, err_frame_d;
    logic              err_timeout_q, err_timeout_d;
    logic              start, byte_done, stop_err, false_start;
    logic [7:0]        byte_data;
    logic [CNT_W-1:0]  tper;

`ifdef SYN_S_INFO_FILT_EN
    logic [1:0] filt_q, filt_d;
    logic       line_f_q, line_f_d;

    always_comb begin
        filt_d   = {filt_q[0], sync_q[1]};
        line_f_d = maj3({sync_q[1], filt_q});
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            filt_q   <= 2'b11;
            line_f_q <= 1'b1;
        end else begin
            filt_q   <= filt_d;
            line_f_q <= line_f_d;
        end
    end

    assign line = line_f_q;
`else
    assign line = sync_q[1];
`endif

    assign sync_d      = {sync_q[0], bus.rx_info};
    assign line_prev_d = line;
    assign fall        = line_prev_q & ~line;
    assign gap_inc     = (&gap_q) ? gap_q : gap_q + GAP_W'(1);
    assign timeout_lim = GAP_W'(TIMEOUT_BITS) * GAP_W'(tper);
    assign brk_lim     = GAP_W'(tper) - GAP_W'(1);

    syn_s_info_rx_byte #(.CNT_W(CNT_W)) u_byte (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .start       (start),
        .line        (line),
        .tbit_period (bus.tbit_period),
        .byte_done   (byte_done),
        .stop_err    (stop_err),
        .false_start (false_start),
        .byte_data   (byte_data),
        .tper        (tper)
    );

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= 2'b11;
            line_prev_q   <= 1'b1;
            state_q       <= S_IDLE;
            byte_cnt_q    <= '0;
            word_q        <= '0;
            gap_q         <= '0;
            utc_sec_q     <= '0;
            utc_valid_q   <= 1'b0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            line_prev_q   <= line_prev_d;
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            word_q        <= word_d;
            gap_q         <= gap_d;
            utc_sec_q     <= utc_sec_d;
            utc_valid_q   <= utc_valid_d;
            err_frame_q   <= err_frame_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // S_START here covers the whole character; the byte sub-module owns its bit phases.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        word_d        = word_q;
        gap_d         = gap_inc;
        utc_sec_d     = utc_sec_q;
        utc_valid_d   = 1'b0;
        err_frame_d   = 1'b0;
        err_timeout_d = 1'b0;
        start         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    start   = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (byte_done) begin
                    gap_d = '0;
                    case (byte_cnt_q)
                        2'd0:    word_d[23:16] = byte_data;
                        2'd1:    word_d[15:8]  = byte_data;
                        default: word_d[7:0]   = byte_data;
                    endcase
                    if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
                        utc_sec_d   = {word_q, byte_data};
                        utc_valid_d = 1'b1;
                        byte_cnt_d  = '0;
                        state_d     = S_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        state_d    = S_GAP;
                    end
                end else if (stop_err) begin
                    err_frame_d = 1'b1;
                    byte_cnt_d  = '0;
                    gap_d       = '0;
                    state_d     = S_BREAK;
                end else if (false_start) begin
                    state_d = (byte_cnt_q != 2'd0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (fall) begin
                    start   = 1'b1;
                    state_d = S_START;
                end else if (gap_q == timeout_lim) begin
                    err_timeout_d = 1'b1;
                    byte_cnt_d    = '0;
                    state_d       = S_IDLE;
                end
            end
            S_BREAK: begin
                gap_d = line ? gap_inc : '0;
                if (line && gap_q == brk_lim) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.utc_sec     = utc_sec_q;
    assign bus.utc_valid   = utc_valid_q;
    assign bus.err_frame   = err_frame_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_syn_s_info_rx.sv
// Directed bench for syn_s_info_rx: word assembly, framing/timeout errors, false start, reset.
module tb_syn_s_info_rx;
    localparam int CNT_W = 20;
    localparam int TPER  = 10;

    logic clk_sys = 1'b0;
    logic rst_n;

    syn_s_info_rx_if #(.CNT_W(CNT_W)) bus ();

    syn_s_info_rx #(.TIMEOUT_BITS(32), .CNT_W(CNT_W)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    int n_valid = 0, n_frame = 0, n_timeout = 0, n_busy = 0, to_cyc = 0;
    int errors = 0, checks = 0;
    int stop_cyc = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (bus.utc_valid)   n_valid   <= n_valid + 1;
        if (bus.err_frame)   n_frame   <= n_frame + 1;
        if (bus.busy)        n_busy    <= n_busy + 1;
        if (bus.err_timeout) begin
            n_timeout <= n_timeout + 1;
            to_cyc    <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All drive tasks start and end on a falling clock edge.
    task automatic send_bit(input logic b);
        bus.rx_info = b;
        repeat (TPER) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        stop_cyc = cyc;
        send_bit(stop);
        repeat (gap) send_bit(1'b1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], 1'b1, gap);
    endtask

    task automatic idle(input int n);
        bus.rx_info = 1'b1;
        repeat (n) @(negedge clk_sys);
    endtask

`ifdef SYN_S_INFO_FILT_EN
    task automatic send_byte_glitch(input logic [7:0] b);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) begin
            for (int c = 0; c < TPER; c++) begin
                bus.rx_info = (c == 8 - i) ? ~b[i] : b[i];
                @(negedge clk_sys);
            end
        end
        send_bit(1'b1);
        send_bit(1'b1);
    endtask
`endif

    initial begin
        int v0, f0, t0, b0;
        rst_n           = 1'b0;
        bus.rx_info     = 1'b1;
        bus.tbit_period = CNT_W'(TPER);
        repeat (3) @(negedge clk_sys);
        chk("rst_utc_sec", bus.utc_sec, 32'h0);
        chk("rst_utc_valid", {31'd0, bus.utc_valid}, 32'd0);
        chk("rst_err_frame", {31'd0, bus.err_frame}, 32'd0);
        chk("rst_err_timeout", {31'd0, bus.err_timeout}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        idle(2 * TPER);

        // 1: single word with one-bit gaps
        send_byte(8'h00, 1'b1, 1);
        send_byte(8'h00, 1'b1, 1);
        send_byte(8'h55, 1'b1, 1);
        send_byte(8'h12, 1'b1, 1);
        idle(TPER);
        chk("t1_utc_sec", bus.utc_sec, 32'h0000_5512);
        chk("t1_valid_cnt", n_valid, 1);
        chk("t1_frame_cnt", n_frame, 0);
        chk("t1_timeout_cnt", n_timeout, 0);
        chk("t1_busy_idle", {31'd0, bus.busy}, 32'd0);

        // 2: two words back-to-back
        send_word(32'h00B7_0001, 0);
        chk("t2_utc_sec_a", bus.utc_sec, 32'h00B7_0001);
        chk("t2_valid_a", n_valid, 2);
        send_word(32'h00B7_0002, 0);
        idle(TPER);
        chk("t2_utc_sec_b", bus.utc_sec, 32'h00B7_0002);
        chk("t2_valid_b", n_valid, 3);

        // 3: bad stop bit on byte 2, then a clean word
        send_byte(8'hAA, 1'b1, 1);
        send_byte(8'hBB, 1'b1, 1);
        send_byte(8'hCC, 1'b0, 2);
        chk("t3_frame_cnt", n_frame, 1);
        chk("t3_utc_hold", bus.utc_sec, 32'h00B7_0002);
        chk("t3_valid_hold", n_valid, 3);
        send_word(32'hCAFE_F00D, 1);
        idle(TPER);
        chk("t3_utc_next", bus.utc_sec, 32'hCAFE_F00D);
        chk("t3_valid_next", n_valid, 4);

        // 4: two bytes then a long idle gap
        send_byte(8'hA1, 1'b1, 0);
        send_byte(8'hA2, 1'b1, 0);
        idle(40 * TPER);
        chk("t4_timeout_cnt", n_timeout, 1);
        chk("t4_timeout_lat", {31'd0, ((to_cyc - stop_cyc) >= 325) && ((to_cyc - stop_cyc) <= 333)}, 32'd1);
        chk("t4_utc_hold", bus.utc_sec, 32'hCAFE_F00D);
        send_word(32'hDEAD_BEEF, 1);
        idle(TPER);
        chk("t4_utc_next", bus.utc_sec, 32'hDEAD_BEEF);
        chk("t4_frame_cnt", n_frame, 1);

        // 5: short low glitch on an idle line
        v0 = n_valid; f0 = n_frame; t0 = n_timeout; b0 = n_busy;
        bus.rx_info = 1'b0;
        repeat (3) @(negedge clk_sys);
        idle(3 * TPER);
        chk("t5_busy_seen", {31'd0, (n_busy - b0) > 0}, 32'd1);
        chk("t5_busy_low", {31'd0, bus.busy}, 32'd0);
        chk("t5_no_valid", n_valid - v0, 0);
        chk("t5_no_error", (n_frame - f0) + (n_timeout - t0), 0);

        // 6: reset during byte 1
        send_byte(8'h77, 1'b1, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        bus.rx_info = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("t6_rst_utc_sec", bus.utc_sec, 32'h0);
        chk("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("t6_rst_valid", {31'd0, bus.utc_valid}, 32'd0);
        rst_n = 1'b1;
        v0 = n_valid;
        idle(2 * TPER);
        send_word(32'h0102_0304, 1);
        idle(TPER);
        chk("t6_utc_next", bus.utc_sec, 32'h0102_0304);
        chk("t6_valid_cnt", n_valid - v0, 1);

`ifdef SYN_S_INFO_FILT_EN
        // 7: single-clock glitches inside every data bit
        v0 = n_valid; f0 = n_frame;
        send_byte_glitch(8'h5A);
        send_byte_glitch(8'hC3);
        send_byte_glitch(8'h0F);
        send_byte_glitch(8'h96);
        idle(TPER);
        chk("t7_utc_glitch", bus.utc_sec, 32'h5AC3_0F96);
        chk("t7_valid_cnt", n_valid - v0, 1);
        chk("t7_frame_cnt", n_frame - f0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
